mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access stage: sequences SRAM and UART strobes for loads/stores
// and freezes the pipeline until the access completes.
module mem_access_unit #(
  parameter int          RAM_WAIT     = 2,
  parameter logic [15:0] IO_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] IO_STAT_ADDR = 16'hBF01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  memReadIn,
  input  logic [1:0]  memWriteIn,
  input  logic [15:0] addrIn,
  input  logic [15:0] dataIn,
  output logic [15:0] ramAddr,
  output logic [15:0] ramDataOut,
  input  logic [15:0] ramDataIn,
  output logic        ramDataOE,
  output logic        ramEN_n,
  output logic        ramOE_n,
  output logic        ramWE_n,
  output logic        uartRdn,
  output logic        uartWrn,
  input  logic [7:0]  uartDataIn,
  input  logic        uartDataReady,
  input  logic        uartTbre,
  input  logic        uartTsre,
  output logic [15:0] readData,
  output logic        done,
  output logic        stall
);

  typedef enum logic [3:0] {
    IDLE, RAM_RD, WR_SETUP, WR_PULSE, WR_HOLD,
    IO_RD, IO_WAITW, IO_WR, DONE
  } stateT;

  localparam logic [3:0] waitLast = 4'(RAM_WAIT - 1);

  stateT       state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [15:0] addrLat, dataLat;
  logic [15:0] addrNext, dataNext;
  logic        accept;
  logic        wrReq, rdReq, reqPresent;
  logic        ioRdOther;

  assign wrReq = (memWriteIn == 2'b01) || (memWriteIn == 2'b10);
  assign rdReq = (memReadIn == 2'b01) || (memReadIn == 2'b10);
  assign reqPresent = wrReq || rdReq;

  assign stall = (state == IDLE && reqPresent)
              || (state != IDLE && state != DONE);

  assign addrNext = accept ? addrIn : addrLat;
  assign dataNext = accept ? dataIn : dataLat;

  // I/O load to an unmapped address completes at once with zero data
  assign ioRdOther = accept && !wrReq && (memReadIn == 2'b10)
                  && (addrIn != IO_DATA_ADDR)
                  && (addrIn != IO_STAT_ADDR);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (reqPresent) begin
          accept = 1'b1;
          if (wrReq) begin
            if (memWriteIn == 2'b01)
              stateNext = WR_SETUP;
            else if (addrIn == IO_DATA_ADDR)
              stateNext = IO_WAITW;
            else
              stateNext = DONE;
          end else if (memReadIn == 2'b01) begin
            stateNext = RAM_RD;
            cntNext   = waitLast;
          end else if (addrIn == IO_DATA_ADDR) begin
            stateNext = IO_RD;
            cntNext   = 4'd1;
          end else if (addrIn == IO_STAT_ADDR) begin
            stateNext = IO_RD;
            cntNext   = 4'd0;
          end else begin
            stateNext = DONE;
          end
        end
      end
      RAM_RD, WR_PULSE, IO_RD, IO_WR: begin
        if (cnt == 4'd0)
          stateNext = (state == WR_PULSE) ? WR_HOLD : DONE;
        else
          cntNext = cnt - 4'd1;
      end
      WR_SETUP: begin
        stateNext = WR_PULSE;
        cntNext   = waitLast;
      end
      WR_HOLD: stateNext = DONE;
      IO_WAITW: begin
        if (uartTbre && uartTsre) begin
          stateNext = IO_WR;
          cntNext   = 4'd1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addrLat    <= 16'h0;
      dataLat    <= 16'h0;
      ramAddr    <= 16'h0;
      ramDataOut <= 16'h0;
      ramDataOE  <= 1'b0;
      ramEN_n    <= 1'b1;
      ramOE_n    <= 1'b1;
      ramWE_n    <= 1'b1;
      uartRdn    <= 1'b1;
      uartWrn    <= 1'b1;
      readData   <= 16'h0;
      done       <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      addrLat <= addrNext;
      dataLat <= dataNext;
      ramAddr <= (stateNext != IDLE) ? addrNext : 16'h0;
      ramEN_n <= !(stateNext inside {RAM_RD, WR_SETUP, WR_PULSE, WR_HOLD});
      ramOE_n <= !(stateNext == RAM_RD);
      ramWE_n <= !(stateNext == WR_PULSE);
      ramDataOE <= stateNext inside {WR_SETUP, WR_PULSE, WR_HOLD, IO_WR};
      uartRdn <= !(stateNext == IO_RD && addrNext == IO_DATA_ADDR);
      uartWrn <= !(stateNext == IO_WR);
      done    <= (stateNext == DONE);
      if (stateNext inside {WR_SETUP, WR_PULSE, WR_HOLD})
        ramDataOut <= dataNext;
      else if (stateNext == IO_WR)
        ramDataOut <= {8'h00, dataNext[7:0]};
      else
        ramDataOut <= 16'h0;
      if (state == RAM_RD && cnt == 4'd0)
        readData <= ramDataIn;
      else if (state == IO_RD && cnt == 4'd0)
        readData <= (addrLat == IO_DATA_ADDR)
                  ? {8'h00, uartDataIn}
                  : {14'b0, uartDataReady, uartTbre & uartTsre};
      else if (ioRdOther)
        readData <= 16'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores, a
// negedge monitor counts strobe/stall cycles and checks each done pulse.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        RST;
  logic [1:0]  memReadIn, memWriteIn;
  logic [15:0] addrIn, dataIn;
  logic [15:0] ramAddr, ramDataOut, ramDataIn;
  logic        ramDataOE, ramEN_n, ramOE_n, ramWE_n;
  logic        uartRdn, uartWrn;
  logic [7:0]  uartDataIn;
  logic        uartDataReady, uartTbre, uartTsre;
  logic [15:0] readData;
  logic        done, stall;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_WAIT(2)) dut (
    .CLK(clk), .RST(RST),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .addrIn(addrIn), .dataIn(dataIn),
    .ramAddr(ramAddr), .ramDataOut(ramDataOut),
    .ramDataIn(ramDataIn), .ramDataOE(ramDataOE),
    .ramEN_n(ramEN_n), .ramOE_n(ramOE_n), .ramWE_n(ramWE_n),
    .uartRdn(uartRdn), .uartWrn(uartWrn),
    .uartDataIn(uartDataIn), .uartDataReady(uartDataReady),
    .uartTbre(uartTbre), .uartTsre(uartTsre),
    .readData(readData), .done(done), .stall(stall)
  );

  typedef struct {
    logic [15:0] rd;
    int stall, oe, we, rdn, wrn;
    logic [15:0] addr, data;
  } expT;

  expT q[$];
  expT cur;
  int checks = 0;
  int errors = 0;
  int nStall, nOe, nWe, nRdn, nWrn;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic expT mk(input logic [15:0] rd, input int st,
      input int oe, input int we, input int rdn, input int wrn,
      input logic [15:0] addr, input logic [15:0] data);
    expT e;
    e.rd = rd; e.stall = st; e.oe = oe; e.we = we;
    e.rdn = rdn; e.wrn = wrn; e.addr = addr; e.data = data;
    return e;
  endfunction

  always @(negedge clk) begin
    if (RST) begin
      q.delete();
      nStall = 0; nOe = 0; nWe = 0; nRdn = 0; nWrn = 0;
    end else begin
      if (stall) nStall++;
      if (!ramOE_n) nOe++;
      if (!ramWE_n) nWe++;
      if (!uartRdn) nRdn++;
      if (!uartWrn) nWrn++;
      if (q.size() > 0) begin
        if (!ramEN_n) chk("ramAddr", 32'(ramAddr), 32'(q[0].addr));
        if (!ramEN_n && ramDataOE)
          chk("ramDataOut", 32'(ramDataOut), 32'(q[0].data));
        if (!ramOE_n) chk("busOffOnRead", 32'(ramDataOE), 32'd0);
        if (!uartWrn) begin
          chk("uartByte", 32'(ramDataOut[7:0]), 32'(q[0].data[7:0]));
          chk("uartBusOE", 32'(ramDataOE), 32'd1);
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spuriousDone: got done=1 want no done");
        end else begin
          cur = q.pop_front();
          chk("readData", 32'(readData), 32'(cur.rd));
          chk("stallCycles", 32'(nStall), 32'(cur.stall));
          chk("oeCycles", 32'(nOe), 32'(cur.oe));
          chk("weCycles", 32'(nWe), 32'(cur.we));
          chk("rdnCycles", 32'(nRdn), 32'(cur.rdn));
          chk("wrnCycles", 32'(nWrn), 32'(cur.wrn));
        end
        nStall = 0; nOe = 0; nWe = 0; nRdn = 0; nWrn = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] rd, input logic [1:0] wr,
      input logic [15:0] addr, input logic [15:0] data,
      input logic [15:0] resp, input int tbreWait, input expT e);
    int n;
    @(posedge clk); #1;
    q.push_back(e);
    memReadIn = rd; memWriteIn = wr;
    addrIn = addr; dataIn = data; ramDataIn = resp;
    if (tbreWait > 0) begin
      uartTbre = 1'b0;
      repeat (tbreWait) @(posedge clk);
      #1 uartTbre = 1'b1;
    end
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done want done within 60 cycles");
    end
    memReadIn = 2'b00; memWriteIn = 2'b00;
  endtask

  initial begin
    RST = 1'b1;
    memReadIn = 2'b00; memWriteIn = 2'b00;
    addrIn = 16'h0; dataIn = 16'h0; ramDataIn = 16'h0;
    uartDataIn = 8'h5A; uartDataReady = 1'b0;
    uartTbre = 1'b1; uartTsre = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstReadData", 32'(readData), 32'd0);
    chk("rstDone", 32'(done), 32'd0);
    chk("rstStall", 32'(stall), 32'd0);
    chk("rstStrobes", 32'({ramEN_n, ramOE_n, ramWE_n, uartRdn, uartWrn}),
        32'h1F);
    chk("rstDataOE", 32'(ramDataOE), 32'd0);
    chk("rstRamAddr", 32'(ramAddr), 32'd0);
    RST = 1'b0;

    issue(2'b01, 2'b00, 16'h0040, 16'h0, 16'h1234, 0,
          mk(16'h1234, 3, 2, 0, 0, 0, 16'h0040, 16'h0));
    issue(2'b00, 2'b01, 16'h0041, 16'hBEEF, 16'h0, 0,
          mk(16'h1234, 5, 0, 2, 0, 0, 16'h0041, 16'hBEEF));
    issue(2'b00, 2'b10, 16'hBF00, 16'h0041, 16'h0, 4,
          mk(16'h1234, 7, 0, 0, 0, 2, 16'hBF00, 16'h0041));
    uartDataReady = 1'b1;
    issue(2'b10, 2'b00, 16'hBF01, 16'h0, 16'h0, 0,
          mk(16'h0003, 2, 0, 0, 0, 0, 16'hBF01, 16'h0));
    uartDataReady = 1'b0;
    issue(2'b10, 2'b00, 16'hBF00, 16'h0, 16'h0, 0,
          mk(16'h005A, 3, 0, 0, 2, 0, 16'hBF00, 16'h0));
    issue(2'b00, 2'b10, 16'hBF05, 16'h0077, 16'h0, 0,
          mk(16'h005A, 1, 0, 0, 0, 0, 16'hBF05, 16'h0077));
    issue(2'b10, 2'b00, 16'hBF02, 16'h0, 16'h0, 0,
          mk(16'h0000, 1, 0, 0, 0, 0, 16'hBF02, 16'h0));
    issue(2'b01, 2'b00, 16'h0100, 16'h0, 16'hA5C3, 0,
          mk(16'hA5C3, 3, 2, 0, 0, 0, 16'h0100, 16'h0));
    issue(2'b01, 2'b01, 16'h0042, 16'h1111, 16'h9999, 0,
          mk(16'hA5C3, 5, 0, 2, 0, 0, 16'h0042, 16'h1111));
    uartDataReady = 1'b1; uartTbre = 1'b0;
    issue(2'b10, 2'b00, 16'hBF01, 16'h0, 16'h0, 0,
          mk(16'h0002, 2, 0, 0, 0, 0, 16'hBF01, 16'h0));
    uartDataReady = 1'b0; uartTbre = 1'b1;

    // Abort a store in the middle of its write pulse
    @(posedge clk); #1;
    q.push_back(mk(16'h0, 0, 0, 0, 0, 0, 16'h0050, 16'hCAFE));
    memWriteIn = 2'b01; addrIn = 16'h0050; dataIn = 16'hCAFE;
    @(posedge clk);
    @(posedge clk); #1;
    RST = 1'b1;
    @(negedge clk);
    chk("abortPreWe", 32'(ramWE_n), 32'd0);
    @(posedge clk); #1;
    RST = 1'b0; memWriteIn = 2'b00;
    chk("abortWe", 32'(ramWE_n), 32'd1);
    chk("abortDataOE", 32'(ramDataOE), 32'd0);
    chk("abortEn", 32'(ramEN_n), 32'd1);
    chk("abortDone", 32'(done), 32'd0);
    chk("abortReadData", 32'(readData), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abortNoDone", 32'(done), 32'd0);
    end

    issue(2'b01, 2'b00, 16'h0043, 16'h0, 16'h7777, 0,
          mk(16'h7777, 3, 2, 0, 0, 0, 16'h0043, 16'h0));

    repeat (3) @(negedge clk);
    chk("queueDrained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
